// File: rtl/confreg_pkg.sv
// +----------------------------------------------------------------------+
// | confreg_pkg : address map, window constants and reset values for    |
// |               the confreg slave.  Rev 1.0                            |
// +----------------------------------------------------------------------+
`default_nettype none
`ifndef XLEN
`define XLEN 32
`endif

package confreg_pkg;

  localparam logic [31:0] CONF_ADDR_BASE = 32'hFFFF_0000;
  localparam logic [31:0] CONF_ADDR_MASK = 32'hFFFF_0000;

  localparam logic [15:0] LED_OFF     = 16'h8000;
  localparam logic [15:0] NUM_OFF     = 16'h8010;
  localparam logic [15:0] SWITCH_OFF  = 16'h8020;
  localparam logic [15:0] BTN_OFF     = 16'h8024;
  localparam logic [15:0] TIMER_OFF   = 16'hE000;
  localparam logic [15:0] TCMP_OFF    = 16'hE004;
  localparam logic [15:0] IRQ_OFF     = 16'hE008;
  localparam logic [15:0] SIMU_OFF    = 16'hF000;
  localparam logic [15:0] IO_SIMU_OFF = 16'hFFEC;
  localparam logic [15:0] TRACE_OFF   = 16'hFFF0;
  localparam logic [15:0] MONITOR_OFF = 16'hFFF4;

  localparam logic OPEN_TRACE_RST  = 1'b1;
  localparam logic NUM_MONITOR_RST = 1'b1;

  // Full in-window address of a register offset.
  function automatic logic [31:0] win_addr(input logic [15:0] off);
    return CONF_ADDR_BASE | {16'h0000, off};
  endfunction

  // Byte-lane merge: lanes with wen set take wdata, the rest keep old.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wen);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/confreg_sync2.sv
// +----------------------------------------------------------------------+
// | confreg_sync2 : two-flop synchronizer for asynchronous board inputs. |
// |                 Rev 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module confreg_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/sirv_gnrl_dfflr.sv
// +----------------------------------------------------------------------+
// | sirv_gnrl_dfflr : load-enabled register with synchronous reset to   |
// |                   a parameterised value.  Rev 1.0                    |
// +----------------------------------------------------------------------+
`default_nettype none

module sirv_gnrl_dfflr #(
  parameter int             DW      = 32,
  parameter logic [DW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_lden,
  input  logic [DW-1:0] i_dnxt,
  output logic [DW-1:0] o_qout
);

  logic [DW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (i_lden) begin
      r_q <= i_dnxt;
    end
  end

  assign o_qout = r_q;

endmodule

`default_nettype wire

// File: rtl/confreg_slave.sv
// +----------------------------------------------------------------------+
// | confreg_slave : conf_* slave for the 0xffff_0000 window: board I/O,  |
// |                 timer with compare IRQ, simulation control.  Rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none
`ifndef XLEN
`define XLEN 32
`endif

module confreg_slave
  import confreg_pkg::*;
#(
  parameter logic SIMU  = 1'b0,
  parameter int   SW_W  = 8,
  parameter int   BTN_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              conf_en,
  input  logic [3:0]        conf_wen,
  input  logic [`XLEN-1:0]  conf_addr,
  input  logic [`XLEN-1:0]  conf_wdata,
  output logic [`XLEN-1:0]  conf_rdata,
  output logic [15:0]       led,
  output logic [31:0]       num_data,
  input  logic [SW_W-1:0]   switch_in,
  input  logic [BTN_W-1:0]  btn_in,
  output logic              timer_irq,
  output logic              open_trace,
  output logic              num_monitor
);

  logic [31:0]      w_addr;
  logic             w_rd;
  logic             w_wr;
  logic [31:0]      w_wr_old;
  logic [31:0]      w_merged;
  logic [31:0]      w_rd_val;
  logic [31:0]      w_timer;
  logic [31:0]      w_timer_inc;
  logic [31:0]      w_timer_nxt;
  logic [31:0]      w_tcmp;
  logic [31:0]      w_io_simu;
  logic [SW_W-1:0]  w_sw_sync;
  logic [BTN_W-1:0] w_btn_sync;
  logic             w_irq_clr;
  logic             w_irq_nxt;

  // Upper address bits are not decoded: fold every address into the window.
  assign w_addr = (conf_addr & ~CONF_ADDR_MASK) | CONF_ADDR_BASE;
  assign w_rd   = conf_en && (conf_wen == 4'b0000);
  assign w_wr   = conf_en && (conf_wen != 4'b0000);

  assign w_timer_inc = w_timer + 32'd1;

  // Pre-write value of the addressed register; the timer merges into its increment.
  always_comb begin
    w_wr_old = '0;
    case (w_addr)
      win_addr(LED_OFF):     w_wr_old = 32'(led);
      win_addr(NUM_OFF):     w_wr_old = num_data;
      win_addr(TIMER_OFF):   w_wr_old = w_timer_inc;
      win_addr(TCMP_OFF):    w_wr_old = w_tcmp;
      win_addr(IO_SIMU_OFF): w_wr_old = w_io_simu;
      win_addr(TRACE_OFF):   w_wr_old = 32'(open_trace);
      win_addr(MONITOR_OFF): w_wr_old = 32'(num_monitor);
      default:               w_wr_old = '0;
    endcase
  end

  assign w_merged = merge_bytes(w_wr_old, conf_wdata, conf_wen);

  always_comb begin
    w_rd_val = '0;
    case (w_addr)
      win_addr(LED_OFF):     w_rd_val = 32'(led);
      win_addr(NUM_OFF):     w_rd_val = num_data;
      win_addr(SWITCH_OFF):  w_rd_val = 32'(w_sw_sync);
      win_addr(BTN_OFF):     w_rd_val = 32'(w_btn_sync);
      win_addr(TIMER_OFF):   w_rd_val = w_timer;
      win_addr(TCMP_OFF):    w_rd_val = w_tcmp;
      win_addr(IRQ_OFF):     w_rd_val = 32'(timer_irq);
      win_addr(SIMU_OFF):    w_rd_val = 32'(SIMU);
      win_addr(IO_SIMU_OFF): w_rd_val = {w_io_simu[15:0], w_io_simu[31:16]};
      win_addr(TRACE_OFF):   w_rd_val = 32'(open_trace);
      win_addr(MONITOR_OFF): w_rd_val = 32'(num_monitor);
      default:               w_rd_val = '0;
    endcase
  end

  assign w_timer_nxt = (w_wr && (w_addr == win_addr(TIMER_OFF))) ? w_merged : w_timer_inc;

  // Clear beats a simultaneous compare hit.
  assign w_irq_clr = w_wr && ((w_addr == win_addr(TCMP_OFF)) ||
                              ((w_addr == win_addr(IRQ_OFF)) && conf_wen[0] && conf_wdata[0]));
  assign w_irq_nxt = !w_irq_clr && (timer_irq || (w_timer == w_tcmp));

  sirv_gnrl_dfflr #(.DW(16)) u_led (
    .clk(clk), .rst(reset),
    .i_lden(w_wr && (w_addr == win_addr(LED_OFF))),
    .i_dnxt(w_merged[15:0]), .o_qout(led)
  );

  sirv_gnrl_dfflr #(.DW(32)) u_num (
    .clk(clk), .rst(reset),
    .i_lden(w_wr && (w_addr == win_addr(NUM_OFF))),
    .i_dnxt(w_merged), .o_qout(num_data)
  );

  sirv_gnrl_dfflr #(.DW(32)) u_timer (
    .clk(clk), .rst(reset),
    .i_lden(1'b1), .i_dnxt(w_timer_nxt), .o_qout(w_timer)
  );

  sirv_gnrl_dfflr #(.DW(32)) u_tcmp (
    .clk(clk), .rst(reset),
    .i_lden(w_wr && (w_addr == win_addr(TCMP_OFF))),
    .i_dnxt(w_merged), .o_qout(w_tcmp)
  );

  sirv_gnrl_dfflr #(.DW(1)) u_irq (
    .clk(clk), .rst(reset),
    .i_lden(1'b1), .i_dnxt(w_irq_nxt), .o_qout(timer_irq)
  );

  sirv_gnrl_dfflr #(.DW(32)) u_io_simu (
    .clk(clk), .rst(reset),
    .i_lden(w_wr && (w_addr == win_addr(IO_SIMU_OFF))),
    .i_dnxt(w_merged), .o_qout(w_io_simu)
  );

  sirv_gnrl_dfflr #(.DW(1), .RST_VAL(OPEN_TRACE_RST)) u_trace (
    .clk(clk), .rst(reset),
    .i_lden(w_wr && (w_addr == win_addr(TRACE_OFF))),
    .i_dnxt(w_merged[0]), .o_qout(open_trace)
  );

  sirv_gnrl_dfflr #(.DW(1), .RST_VAL(NUM_MONITOR_RST)) u_monitor (
    .clk(clk), .rst(reset),
    .i_lden(w_wr && (w_addr == win_addr(MONITOR_OFF))),
    .i_dnxt(w_merged[0]), .o_qout(num_monitor)
  );

  sirv_gnrl_dfflr #(.DW(32)) u_rdata (
    .clk(clk), .rst(reset),
    .i_lden(w_rd), .i_dnxt(w_rd_val), .o_qout(conf_rdata)
  );

  confreg_sync2 #(.WIDTH(SW_W)) u_sw_sync (
    .clk(clk), .rst(reset), .i_d(switch_in), .o_q(w_sw_sync)
  );

  confreg_sync2 #(.WIDTH(BTN_W)) u_btn_sync (
    .clk(clk), .rst(reset), .i_d(btn_in), .o_q(w_btn_sync)
  );

endmodule

`default_nettype wire

// File: tb/tb_confreg_slave.sv
// +----------------------------------------------------------------------+
// | tb_confreg_slave : directed and random stimulus for confreg_slave,   |
// |                    checked against a register-map model.  Rev 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_confreg_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        conf_en = 1'b0;
  logic [3:0]  conf_wen = 4'h0;
  logic [31:0] conf_addr = 32'h0;
  logic [31:0] conf_wdata = 32'h0;
  logic [31:0] conf_rdata;
  logic [15:0] led;
  logic [31:0] num_data;
  logic [7:0]  switch_in = 8'h00;
  logic [3:0]  btn_in = 4'h0;
  logic        timer_irq;
  logic        open_trace;
  logic        num_monitor;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  confreg_slave #(.SIMU(1'b0), .SW_W(8), .BTN_W(4)) dut (
    .clk(clk), .reset(reset), .conf_en(conf_en), .conf_wen(conf_wen),
    .conf_addr(conf_addr), .conf_wdata(conf_wdata), .conf_rdata(conf_rdata),
    .led(led), .num_data(num_data), .switch_in(switch_in), .btn_in(btn_in),
    .timer_irq(timer_irq), .open_trace(open_trace), .num_monitor(num_monitor)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_rw [int];
  logic [31:0] m_timer, m_tcmp, m_rdata;
  logic        m_irq;
  logic [7:0]  m_sw [2];
  logic [3:0]  m_btn [2];

  function automatic logic [31:0] rw_mask(input int off);
    case (off)
      'h8000:                  return 32'h0000_FFFF;
      'h8010, 'hFFEC:          return 32'hFFFF_FFFF;
      'hFFF0, 'hFFF4:          return 32'h0000_0001;
      default:                 return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input int off);
    logic [31:0] v;
    case (off)
      'h8000, 'h8010, 'hFFF0, 'hFFF4: return m_rw[off];
      'hFFEC: begin v = m_rw[off]; return {v[15:0], v[31:16]}; end
      'h8020: return {24'h0, m_sw[1]};
      'h8024: return {28'h0, m_btn[1]};
      'hE000: return m_timer;
      'hE004: return m_tcmp;
      'hE008: return {31'h0, m_irq};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] wen);
    logic [31:0] v;
    v = old;
    for (int i = 0; i < 4; i++) if (wen[i]) v[8*i +: 8] = d[8*i +: 8];
    return v;
  endfunction

  always @(posedge clk) begin
    int          off;
    bit          rd, wr, hit, clr;
    logic [31:0] rv, nt;
    if (reset) begin
      m_rw['h8000] = 0; m_rw['h8010] = 0; m_rw['hFFEC] = 0;
      m_rw['hFFF0] = 1; m_rw['hFFF4] = 1;
      m_timer = 0; m_tcmp = 0; m_irq = 0; m_rdata = 0;
      m_sw[0] = 0; m_sw[1] = 0; m_btn[0] = 0; m_btn[1] = 0;
    end else begin
      off = int'(conf_addr[15:0]);
      rd  = conf_en && (conf_wen == 0);
      wr  = conf_en && (conf_wen != 0);
      rv  = m_read(off);
      hit = (m_timer == m_tcmp);
      nt  = m_timer + 1;
      clr = 0;
      if (wr) begin
        if (rw_mask(off) != 0) m_rw[off] = lanes(m_rw[off], conf_wdata, conf_wen) & rw_mask(off);
        if (off == 'hE000) nt = lanes(nt, conf_wdata, conf_wen);
        if (off == 'hE004) begin m_tcmp = lanes(m_tcmp, conf_wdata, conf_wen); clr = 1; end
        if (off == 'hE008 && conf_wen[0] && conf_wdata[0]) clr = 1;
      end
      m_irq   = clr ? 1'b0 : (m_irq | hit);
      m_timer = nt;
      m_sw[1] = m_sw[0];   m_sw[0] = switch_in;
      m_btn[1] = m_btn[0]; m_btn[0] = btn_in;
      if (rd) m_rdata = rv;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e_led;
    if (chk_en) begin
      e_led = m_rw['h8000];
      check("model_rdata", conf_rdata, m_rdata);
      check("model_led", {16'h0, led}, e_led);
      check("model_num", num_data, m_rw['h8010]);
      check("model_irq", {31'h0, timer_irq}, {31'h0, m_irq});
      check("model_trace", {31'h0, open_trace}, m_rw['hFFF0]);
      check("model_monitor", {31'h0, num_monitor}, m_rw['hFFF4]);
    end
  end

  task automatic cyc(input logic en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wd);
    conf_en = en; conf_wen = wen; conf_addr = addr; conf_wdata = wd;
    @(negedge clk);
  endtask

  localparam logic [15:0] OFFS [12] = '{16'h8000, 16'h8010, 16'h8020, 16'h8024,
                                        16'hE000, 16'hE004, 16'hE008, 16'hF000,
                                        16'hFFEC, 16'hFFF0, 16'hFFF4, 16'h9000};

  initial begin
    @(negedge clk);
    reset = 1'b1;
    repeat (3) cyc(1'b0, 4'h0, 32'h0, 32'h0);
    chk_en = 1'b1;
    // reset state
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    check("rst_trace", {31'h0, open_trace}, 32'h1);
    check("rst_monitor", {31'h0, num_monitor}, 32'h1);
    check("rst_rdata", conf_rdata, 32'h0);
    reset = 1'b0;
    cyc(1'b1, 4'h0, 32'hFFFF_FFF0, 32'h0); check("rd_trace", conf_rdata, 32'h1);
    cyc(1'b1, 4'h0, 32'hFFFF_FFF4, 32'h0); check("rd_monitor", conf_rdata, 32'h1);
    cyc(1'b1, 4'h0, 32'hFFFF_8000, 32'h0); check("rd_led0", conf_rdata, 32'h0);
    // byte-lane LED write
    cyc(1'b1, 4'b0001, 32'hFFFF_8000, 32'hFFFF_ABCD);
    check("led_lane0", {16'h0, led}, 32'h0000_00CD);
    cyc(1'b1, 4'h0, 32'hFFFF_8000, 32'h0); check("rd_led", conf_rdata, 32'h0000_00CD);
    // timer write then read 5 cycles later
    cyc(1'b1, 4'hF, 32'hFFFF_E000, 32'h0000_0010);
    repeat (5) cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b1, 4'h0, 32'hFFFF_E000, 32'h0); check("rd_timer", conf_rdata, 32'h0000_0015);
    // compare interrupt
    cyc(1'b1, 4'hF, 32'hFFFF_E004, 32'h0000_0020);
    check("irq_cmp_clr", {31'h0, timer_irq}, 32'h0);
    cyc(1'b1, 4'hF, 32'hFFFF_E000, 32'h0000_001E);
    cyc(1'b0, 4'h0, 32'h0, 32'h0); check("irq_b1", {31'h0, timer_irq}, 32'h0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0); check("irq_b2", {31'h0, timer_irq}, 32'h0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0); check("irq_b3", {31'h0, timer_irq}, 32'h1);
    repeat (3) cyc(1'b0, 4'h0, 32'h0, 32'h0);
    check("irq_sticky", {31'h0, timer_irq}, 32'h1);
    cyc(1'b1, 4'h1, 32'hFFFF_E008, 32'h0000_0001);
    check("irq_w1c", {31'h0, timer_irq}, 32'h0);
    // switch synchronizer latency
    switch_in = 8'hA5;
    cyc(1'b1, 4'h0, 32'hFFFF_8020, 32'h0); check("sw_edge1", conf_rdata, 32'h0);
    cyc(1'b1, 4'h0, 32'hFFFF_8020, 32'h0); check("sw_edge2", conf_rdata, 32'h0);
    cyc(1'b1, 4'h0, 32'hFFFF_8020, 32'h0); check("sw_edge3", conf_rdata, 32'h0000_00A5);
    // IO_SIMU halfword swap and unmapped read
    cyc(1'b1, 4'hF, 32'hFFFF_FFEC, 32'h1234_5678);
    cyc(1'b1, 4'h0, 32'hFFFF_FFEC, 32'h0); check("rd_io_simu", conf_rdata, 32'h5678_1234);
    cyc(1'b1, 4'h0, 32'hFFFF_9000, 32'h0); check("rd_unmapped", conf_rdata, 32'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] off;
      logic [3:0]  wen;
      logic [31:0] wd;
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 4) == 0) switch_in = 8'($urandom);
      if ($urandom_range(0, 4) == 0) btn_in = 4'($urandom);
      off = ($urandom_range(0, 9) == 0) ? 16'($urandom) : OFFS[$urandom_range(0, 11)];
      wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      wd  = $urandom;
      if (off == 16'hE004 && $urandom_range(0, 1) == 0) wd = m_timer + $urandom_range(2, 20);
      if (off == 16'hE000 && $urandom_range(0, 3) != 0) wen = 4'h0;
      cyc($urandom_range(0, 3) != 0, wen, {16'($urandom), off}, wd);
    end
    reset = 1'b0;
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
